// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: port 0 is a read-only fetch port, port 1 a read/write data port.
// Round-robin on contention, one word per transaction, misaligned requests answered with err.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a request; winner is picked and latched here
// ACCESS | single-cycle memory strobe with the latched address/data
// RESP   | one-cycle ack (and err) to the winning port
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]    state;
  logic          grant;
  logic          lat_we;
  logic          last_grant;

  logic          any_req;
  logic          pick1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic          misaligned;

  // last_grant resets to 1 so that port 0 wins the first contention
  always_comb begin
    any_req    = req0 | req1;
    pick1      = req1 & (~req0 | ~last_grant);
    sel_addr   = pick1 ? addr1 : addr0;
    sel_wdata  = pick1 ? wdata1 : '0;
    sel_we     = pick1 & we1;
    misaligned = (sel_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      lat_we     <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= pick1;
            lat_we <= sel_we;
            busy   <= 1'b1;
            if (misaligned) begin
              // error path never touches memory; mem_addr/mem_wdata keep old values
              state <= RESP;
              if (pick1) begin
                ack1   <= 1'b1;
                err1   <= 1'b1;
                rdata1 <= '0;
              end else begin
                ack0   <= 1'b1;
                err0   <= 1'b1;
                rdata0 <= '0;
              end
            end else begin
              state     <= ACCESS;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_read  <= ~sel_we;
              mem_write <= sel_we;
            end
          end
        end
        ACCESS: begin
          state <= RESP;
          if (grant) begin
            ack1   <= 1'b1;
            rdata1 <= lat_we ? '0 : mem_rdata;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= mem_rdata;
          end
        end
        RESP: begin
          state      <= IDLE;
          busy       <= 1'b0;
          last_grant <= grant;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits (one word = 4 bytes).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0  in  1  port 0 (fetch, read-only) request; held with addr0 stable until ack0.
REQ-006 addr0  in  AW  port 0 byte address.
REQ-007 ack0 / err0  out  1 each  port 0 completion pulse / misalignment flag.
REQ-008 rdata0  out  DW  port 0 read data.
REQ-009 req1 / we1  in  1 each  port 1 (data) request / write enable (1 = write); held with addr1, wdata1 stable until ack1.
REQ-010 addr1 / wdata1  in  AW / DW  port 1 byte address / write data.
REQ-011 ack1 / err1  out  1 each  port 1 completion pulse / misalignment flag.
REQ-012 rdata1  out  DW  port 1 read data.
REQ-013 mem_addr / mem_wdata  out  AW / DW  address / write data to shared memory.
REQ-014 mem_read / mem_write  out  1 each  memory read / write strobe; memory writes on clk edge while mem_write=1.
REQ-015 mem_rdata  in  DW  combinational memory read data.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ACCESS, RESP; all outputs are registered.
REQ-018 IDLE: if neither request is high, the block stays in IDLE with all strobes and acks low.
REQ-019 IDLE with request(s): the block latches the winner's port id, address, we (0 for port 0) and wdata, then transitions.
REQ-020 Arbitration: single request wins; on simultaneous requests the port not granted last wins (round-robin); after reset port 0 has priority.
REQ-021 Alignment: latched address with addr[1:0] != 0 goes IDLE -> RESP directly, with err set and no memory strobe ever asserted.
REQ-022 Aligned request: IDLE -> ACCESS; during ACCESS, mem_addr = latched address, mem_wdata = latched wdata, and mem_read = ~we or mem_write = we, each for exactly one cycle.
REQ-023 ACCESS read: mem_rdata is captured at the ACCESS->RESP edge; ACCESS -> RESP unconditionally.
REQ-024 RESP: winner's ack is high for exactly one cycle; err reflects the alignment result; the other port's ack stays 0.
REQ-025 RESP read: the winner's rdata is updated to the captured word; write or error: rdata is set to 0.
REQ-026 rdata0/rdata1 SHALL hold their value until that port's next ack.
REQ-027 RESP -> IDLE unconditionally; the last-grant pointer updates on this transition.
REQ-028 Latency: a request sampled in IDLE at edge N gives ack high in cycle N+2 when aligned, N+1 when misaligned; throughput is at most one transaction per 3 cycles.
REQ-029 A request still high in the IDLE cycle after its ack SHALL be treated as a new transaction.
REQ-030 Requests arriving outside IDLE SHALL be ignored until IDLE; no input changes are captured mid-transaction.
REQ-031 mem_addr and mem_wdata SHALL hold their last values outside ACCESS; strobes are 0 outside ACCESS.

Reset
REQ-032 While reset is high at a clock edge, the block SHALL go to IDLE and zero all outputs (ack*, err*, rdata*, mem_*, busy), with port 0 priority.
REQ-033 Reset asserted in ACCESS or RESP aborts the transaction: no ack is issued, and mem_write is 0 from the next cycle.

Verification
REQ-034 Read: mem word at 16 = 0x0000ABCD; after reset, req0=1, addr0=16 -> mem_read for one cycle at mem_addr=16; ack0=1, err0=0, rdata0=0x0000ABCD two cycles after acceptance.
REQ-035 Write: req1=1, we1=1, addr1=20, wdata1=0x14 -> mem_write high exactly one cycle with mem_addr=20, mem_wdata=0x14; ack1=1, err1=0, rdata1=0; a following port 0 read of 20 returns 0x14.
REQ-036 Misaligned: req1=1, we1=1, addr1=19, wdata1=20 -> ack1=1, err1=1 one cycle after acceptance; mem_write and mem_read never asserted; memory contents unchanged.
REQ-037 Contention: req0 and req1 held high continuously from reset -> ack order 0,1,0,1,... with acks exactly 3 cycles apart; no cycle has ack0 and ack1 both high.
REQ-038 Abort: reset asserted during ACCESS of a port 1 write -> no ack1; all outputs 0 on the following cycle; busy=0; next request is served normally.
